cache_axi_arbiter: RTL

Parametrised successor to the two-port cache/memory bus. Arbitrates line-sized load/store requests from CONNECTIONS cache clients onto one AXI4 master port, round-robin fair. Performs full read bursts and full write bursts, including the W-channel handshake, WLAST and B-response. Sits between the L1 I/D caches (and any future L2 port) and the system memory interconnect.

---
 rtl/cache_bus_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/cache_axi_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_pkg.sv
// Shared types and AXI constants for the cache-to-AXI line arbiter.
// Used by cache_axi_arbiter and its round-robin sub-module.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    RD_DONE = 3'd3,
    WR_ADDR = 3'd4,
    WR_DATA = 3'd5,
    WR_RESP = 3'd6
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] CACHE_ATTR = 4'b0011;

  function automatic int beats(input int chunks_log);
    return 1 << chunks_log;
  endfunction

  function automatic int line_bits(input int data_width, input int chunks_log);
    return data_width * beats(chunks_log);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so non-power-of-two client counts rotate correctly.
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter moving whole cache lines between N clients and one AXI4 master.
// Define CACHE_SNOOP_EN to add the AC snoop channel and the snoop broadcast outputs.
module cache_axi_arbiter
  import cache_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int CHUNKS_LOG  = 3,
  parameter int CONNECTIONS = 2,
  localparam int BEATS = beats(CHUNKS_LOG),
  localparam int LINE  = line_bits(DATA_WIDTH, CHUNKS_LOG),
  localparam int IDXW  = $clog2(CONNECTIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CONNECTIONS-1:0]        command_valid,
  input  logic [CONNECTIONS-1:0]        command_store,
  input  logic [CONNECTIONS-1:0]        command_rready,
  input  logic [CONNECTIONS*ADDR_WIDTH-1:0] command_addr,
  input  logic [CONNECTIONS*LINE-1:0]   data_in,
  output logic [CONNECTIONS-1:0]        bus_ready,
  output logic [CONNECTIONS-1:0]        bus_valid,
  output logic                          bus_err,
  output logic [LINE-1:0]               data_out,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
`ifdef CACHE_SNOOP_EN
  input  logic                          m_axi_acvalid,
  output logic                          m_axi_acready,
  input  logic [ADDR_WIDTH-1:0]         m_axi_acaddr,
  input  logic [3:0]                    m_axi_acsnoop,
  output logic [CONNECTIONS-1:0]        snoop_valid,
  output logic [ADDR_WIDTH-1:0]         snoop_addr,
`endif
  output logic [2:0]                    dbg_state_o
);

  localparam int OFF_BITS = $clog2(LINE / 8);
  localparam logic [CHUNKS_LOG-1:0] LAST_BEAT = '1;

  state_e                 state_q, state_d;
  logic [CHUNKS_LOG-1:0]  cnt_q, cnt_d;
  logic [IDXW-1:0]        rr_q, rr_d, grant_q, grant_d;
  logic                   err_q, err_d, store_q, store_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE-1:0]        line_q, line_d;
  logic [CONNECTIONS-1:0] arb_grant;
  logic [IDXW-1:0]        arb_idx;
  logic                   arb_any;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   snoop_req;

  rr_arbiter #(.N(CONNECTIONS)) u_rr (
    .req_i   (command_valid),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign sel_addr = command_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];

  // Handshake rule on every channel: a transfer happens on the clk edge where
  // valid and ready are both high; a valid, once raised, holds until that edge.
`ifdef CACHE_SNOOP_EN
  assign snoop_req     = m_axi_acvalid;
  assign m_axi_acready = (state_q == IDLE) && m_axi_acvalid && !reset;
  assign snoop_valid   = {CONNECTIONS{m_axi_acready}};
  assign snoop_addr    = {m_axi_acaddr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  logic unused_snoop;
  assign unused_snoop = &{1'b0, m_axi_acsnoop, m_axi_acaddr[OFF_BITS-1:0]};
`else
  assign snoop_req = 1'b0;
`endif

  logic unused_in;
  assign unused_in = &{1'b0, m_axi_rlast, sel_addr[OFF_BITS-1:0]};

  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arcache = CACHE_ATTR;
  assign m_axi_awcache = CACHE_ATTR;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign data_out      = line_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    err_d   = err_q;
    store_d = store_q;
    addr_d  = addr_q;
    line_d  = line_q;
    bus_ready     = '0;
    bus_valid     = '0;
    bus_err       = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A pending snoop takes this IDLE cycle; requests wait one more.
        if (!reset && !snoop_req && arb_any) begin
          bus_ready = arb_grant;
          grant_d   = arb_idx;
          store_d   = command_store[arb_idx];
          addr_d    = {sel_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
          line_d    = data_in[arb_idx*LINE +: LINE];
          rr_d      = (arb_idx == IDXW'(CONNECTIONS - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = command_store[arb_idx] ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
          if (m_axi_rresp != RESP_OKAY) err_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        bus_valid[grant_q] = 1'b1;
        bus_err            = err_q;
        if (command_rready[grant_q]) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = (cnt_q == LAST_BEAT);
        if (m_axi_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          bus_valid[grant_q] = 1'b1;
          bus_err            = (m_axi_bresp != RESP_OKAY);
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

endmodule
